mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
Control and handshake stage that sits directly upstream of the 32x32 shift-add multiplier datapath.
- Accepts an operand pair over a valid/ready request port and latches it.
- Sequences the datapath's load, add, shift and increment strobes from its product-LSB and counter-below-32 status.
- Captures the 64-bit product and presents it on a valid/ready response port.

Parameters:
FUSED_STEP, 1, 1 = add and shift in the same cycle (one cycle per bit); 0 = separate ADD and SHIFT cycles (textbook three-state loop).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  operand pair offered
req_ready  out  1  block can accept; high only in IDLE
req_mcand  in  32  multiplicand
req_mplier  in  32  multiplier
resp_valid  out  1  product available
resp_ready  in  1  consumer accepts product
resp_product  out  64  unsigned product
busy  out  1  high in every state except IDLE
dp_load  out  1  drives datapath rst (loads {32'b0, multiplier}, clears counter)
dp_add  out  1  datapath add strobe
dp_shr  out  1  datapath shift-right strobe
dp_incr  out  1  datapath counter increment
dp_mcand  out  32  registered multiplicand to datapath
dp_mplier  out  32  registered multiplier to datapath
dp_write  in  1  datapath product[0]
dp_less32  in  1  datapath counter < 32
dp_result  in  64  datapath registered result

Behaviour:
- States: IDLE, LOAD, TEST, ADD, SHIFT, DONE. The ADD and SHIFT states are used only when FUSED_STEP=0.
- Reset values:
  - state IDLE, req_ready 1, busy 0, resp_valid 0, resp_product 0.
  - dp_mcand 0, dp_mplier 0.
  - dp_add, dp_shr, dp_incr 0.
  - dp_load 1, so the datapath is held cleared during reset. dp_load falls at the first clock edge in IDLE.
- dp_load is a flop output, glitch-free, high exactly for the LOAD state cycle. dp_mplier and dp_mcand are stable throughout that cycle.
- IDLE: on req_valid&req_ready, capture req_mcand/req_mplier into dp_mcand/dp_mplier and go to LOAD.
- LOAD: go to TEST unconditionally.
- TEST with FUSED_STEP=1:
  - if dp_less32: dp_add=dp_write, dp_shr=1, dp_incr=1; stay in TEST.
  - else: capture dp_result into resp_product, set resp_valid, go to DONE.
- TEST with FUSED_STEP=0:
  - if dp_less32: go to ADD when dp_write, else go to SHIFT; no strobes are asserted.
  - else: capture and go to DONE as in fused mode.
- ADD: dp_add=1, go to SHIFT.
- SHIFT: dp_shr=1, dp_incr=1, go to TEST.
- dp_add/dp_shr/dp_incr are combinational decodes of state, dp_write and dp_less32 only. They never depend on the req_* or resp_* ports.
- DONE:
  - resp_valid=1; resp_product is held stable until the handshake.
  - On resp_ready, clear resp_valid and go to IDLE.
  - req_ready stays 0 in DONE; there is no same-cycle turnaround.
- Latency, counted in clock edges from the request-handshake edge to resp_valid rising:
  - FUSED_STEP=1: 34.
  - FUSED_STEP=0: 66 + popcount(multiplier).
- Arithmetic: unsigned 32x32 to 64, exact, with no overflow path. The datapath's adder carry-out is ignored by design.
- req_valid is ignored outside IDLE. Request operands are sampled only at the handshake edge.
- Reset mid-operation: all state returns to reset values immediately and dp_load goes to 1. Any partial product is discarded.
- resp_ready asserted while resp_valid=0 has no effect.

Decomposition:
- Shared package mul_pkg holds:
  - the state enum (IDLE, LOAD, TEST, ADD, SHIFT, DONE);
  - MUL_WIDTH=32 and PROD_WIDTH=64;
  - latency constants LAT_FUSED=34 and LAT_SPLIT_BASE=66, which the bench also uses.
- No sub-module. The strobe decode is a single function inside mul_sequencer, and the bench instantiates mul_sequencer together with the existing datapath.

Test Plan:
1. FUSED_STEP=1, 3 x 5, resp_ready=1 -> resp_product 64'd15; resp_valid 34 edges after handshake; dp_load high exactly one cycle.
2. FUSED_STEP=1, 0xFFFFFFFF x 0xFFFFFFFF -> resp_product 64'hFFFFFFFE_00000001; dp_add high on all 32 step cycles.
3. FUSED_STEP=0, 7 x 0x0000000B -> 64'd77; latency 69 edges; exactly 3 ADD cycles and 32 SHIFT cycles.
4. Multiplier 0, mcand 0xDEADBEEF -> 64'd0; dp_add never asserted; busy 1 from LOAD through DONE.
5. Backpressure: resp_ready low 10 cycles after resp_valid -> resp_product stable, req_ready 0, second req_valid ignored; the second operand pair 2 x 9 is accepted only after return to IDLE and yields 18.
6. Reset pulse at step 10 of 0x12345678 x 0x9ABCDEF0 -> outputs at reset values, dp_load 1 during reset; next op 6 x 7 -> 64'd42 with nominal latency.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-add multiplier control slice.
package mul_pkg;

  localparam int unsigned MUL_WIDTH      = 32;
  localparam int unsigned PROD_WIDTH     = 64;
  localparam int unsigned LAT_FUSED      = 34;
  localparam int unsigned LAT_SPLIT_BASE = 66;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TEST,
    ADD,
    SHIFT,
    DONE
  } state_t;

  typedef struct packed {
    logic [MUL_WIDTH-1:0] mcand;
    logic [MUL_WIDTH-1:0] mplier;
  } mul_req_t;

  typedef struct packed {
    logic add;
    logic shr;
    logic incr;
  } dp_strobe_t;

endpackage

// File: rtl/mul_sequencer.sv
// Request/response handshake and strobe sequencing for the 32x32 shift-add datapath.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter bit FUSED_STEP = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [MUL_WIDTH-1:0]  req_mcand,
  input  logic [MUL_WIDTH-1:0]  req_mplier,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [PROD_WIDTH-1:0] resp_product,
  output logic                  busy,
  output logic                  dp_load,
  output logic                  dp_add,
  output logic                  dp_shr,
  output logic                  dp_incr,
  output logic [MUL_WIDTH-1:0]  dp_mcand,
  output logic [MUL_WIDTH-1:0]  dp_mplier,
  input  logic                  dp_write,
  input  logic                  dp_less32,
  input  logic [PROD_WIDTH-1:0] dp_result
);

  state_t                  state_q, state_d;
  mul_req_t                opnd_q;
  logic [PROD_WIDTH-1:0]   product_q;
  logic                    req_ready_q, busy_q, resp_valid_q, dp_load_q;
  logic                    accept, finish;
  dp_strobe_t              strobe_c;

  // Datapath strobes depend only on state and datapath status.
  function automatic dp_strobe_t decode_strobes(state_t st, logic write, logic less32);
    dp_strobe_t s;
    s = '0;
    case (st)
      TEST: begin
        if (FUSED_STEP && less32) begin
          s.add  = write;
          s.shr  = 1'b1;
          s.incr = 1'b1;
        end
      end
      ADD:   s.add = 1'b1;
      SHIFT: begin
        s.shr  = 1'b1;
        s.incr = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

  assign accept   = (state_q == IDLE) && req_valid && req_ready_q;
  assign finish   = (state_q == TEST) && !dp_less32;
  assign strobe_c = decode_strobes(state_q, dp_write, dp_less32);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = LOAD;
      LOAD:  state_d = TEST;
      TEST: begin
        if (!dp_less32)       state_d = DONE;
        else if (!FUSED_STEP) state_d = dp_write ? ADD : SHIFT;
      end
      ADD:   state_d = SHIFT;
      SHIFT: state_d = TEST;
      DONE:  if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags and dp_load are decoded from next state so they are glitch-free flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      dp_load_q    <= 1'b1;
      opnd_q       <= '0;
      product_q    <= '0;
    end else begin
      req_ready_q  <= (state_d == IDLE);
      busy_q       <= (state_d != IDLE);
      resp_valid_q <= (state_d == DONE);
      dp_load_q    <= (state_d == LOAD);
      if (accept) opnd_q <= mul_req_t'{mcand: req_mcand, mplier: req_mplier};
      if (finish) product_q <= dp_result;
    end
  end

  assign req_ready    = req_ready_q;
  assign busy         = busy_q;
  assign resp_valid   = resp_valid_q;
  assign resp_product = product_q;
  assign dp_load      = dp_load_q;
  assign dp_mcand     = opnd_q.mcand;
  assign dp_mplier    = opnd_q.mplier;
  assign dp_add       = strobe_c.add;
  assign dp_shr       = strobe_c.shr;
  assign dp_incr      = strobe_c.incr;

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench: split (ch0) and fused (ch1) sequencers, each driving a shift-add datapath model.
module tb_mul_sequencer;
  import mul_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready, busy;
  logic [1:0]  dp_load, dp_add, dp_shr, dp_incr, dp_write, dp_less32;
  logic [31:0] req_mcand [2];
  logic [31:0] req_mplier [2];
  logic [31:0] dp_mcand [2];
  logic [31:0] dp_mplier [2];
  logic [63:0] resp_product [2];
  logic [63:0] dp_result [2];

  // Datapath model: {carry, hi, lo} so an add carry is shifted back in.
  logic [64:0] dp_acc [2];
  logic [5:0]  dp_cnt [2];
  logic [64:0] dp_nxt;

  int unsigned cyc = 0;
  int unsigned cnt_load [2] = '{0, 0};
  int unsigned cnt_add [2]  = '{0, 0};
  int unsigned cnt_shr [2]  = '{0, 0};
  int unsigned cnt_incr [2] = '{0, 0};
  int unsigned cnt_idle [2] = '{0, 0};

  typedef struct packed {
    logic [63:0] prod;
    int unsigned lat;
    int unsigned hs;
  } exp_t;

  exp_t sb_q [2][$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mul_sequencer #(.FUSED_STEP(1'b0)) u_split (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_mcand(req_mcand[0]), .req_mplier(req_mplier[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_product(resp_product[0]),
    .busy(busy[0]), .dp_load(dp_load[0]), .dp_add(dp_add[0]), .dp_shr(dp_shr[0]),
    .dp_incr(dp_incr[0]), .dp_mcand(dp_mcand[0]), .dp_mplier(dp_mplier[0]),
    .dp_write(dp_write[0]), .dp_less32(dp_less32[0]), .dp_result(dp_result[0])
  );

  mul_sequencer #(.FUSED_STEP(1'b1)) u_fused (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_mcand(req_mcand[1]), .req_mplier(req_mplier[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_product(resp_product[1]),
    .busy(busy[1]), .dp_load(dp_load[1]), .dp_add(dp_add[1]), .dp_shr(dp_shr[1]),
    .dp_incr(dp_incr[1]), .dp_mcand(dp_mcand[1]), .dp_mplier(dp_mplier[1]),
    .dp_write(dp_write[1]), .dp_less32(dp_less32[1]), .dp_result(dp_result[1])
  );

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (dp_load[g]) begin
        dp_acc[g] <= {33'd0, dp_mplier[g]};
        dp_cnt[g] <= 6'd0;
      end else begin
        dp_nxt = dp_acc[g];
        if (dp_add[g]) dp_nxt[64:32] = {1'b0, dp_nxt[63:32]} + {1'b0, dp_mcand[g]};
        if (dp_shr[g]) dp_nxt = dp_nxt >> 1;
        dp_acc[g] <= dp_nxt;
        if (dp_incr[g]) dp_cnt[g] <= dp_cnt[g] + 6'd1;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_dp
    assign dp_write[g]  = dp_acc[g][0];
    assign dp_less32[g] = (dp_cnt[g] < 6'd32);
    assign dp_result[g] = dp_acc[g][63:0];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 2; g++) begin
      cnt_load[g] <= cnt_load[g] + 32'(dp_load[g]);
      cnt_add[g]  <= cnt_add[g]  + 32'(dp_add[g]);
      cnt_shr[g]  <= cnt_shr[g]  + 32'(dp_shr[g]);
      cnt_incr[g] <= cnt_incr[g] + 32'(dp_incr[g]);
      cnt_idle[g] <= cnt_idle[g] + 32'(!busy[g]);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Latency is checked when resp_valid rises; product when the response is consumed.
  task automatic monitor();
    logic [1:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (rst) prev[g] = 1'b0;
        else begin
          if (resp_valid[g] && !prev[g]) begin
            if (sb_q[g].size() == 0)
              check($sformatf("ch%0d_resp_unexpected", g), 64'(resp_valid[g]), 64'd0);
            else
              check($sformatf("ch%0d_latency", g), 64'(cyc - sb_q[g][0].hs), 64'(sb_q[g][0].lat));
          end
          if (resp_valid[g] && resp_ready[g] && sb_q[g].size() != 0) begin
            e = sb_q[g].pop_front();
            check($sformatf("ch%0d_product", g), resp_product[g], e.prod);
          end
          prev[g] = resp_valid[g];
        end
      end
    end
  endtask

  task automatic issue(input int ch, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   got;
    req_mcand[ch]  = a;
    req_mplier[ch] = b;
    req_valid[ch]  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = req_ready[ch];
    end
    check($sformatf("ch%0d_req_accept", ch), 64'(got), 64'd1);
    if (!got) begin
      req_valid[ch] = 1'b0;
      return;
    end
    step();
    req_valid[ch] = 1'b0;
    e.prod = 64'(a) * 64'(b);
    e.lat  = (ch == 1) ? LAT_FUSED : LAT_SPLIT_BASE + 32'($countones(b));
    e.hs   = cyc;
    sb_q[ch].push_back(e);
  endtask

  task automatic wait_resp(input int ch, input bit level, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = (resp_valid[ch] == level);
    end
    check($sformatf("ch%0d_%s", ch, name), 64'(got), 64'd1);
  endtask

  task automatic run_op(input int ch, input logic [31:0] a, input logic [31:0] b, input int hold);
    int unsigned s_load, s_add, s_shr, s_incr, s_idle;
    logic [63:0] prod;
    prod = 64'(a) * 64'(b);
    step();
    resp_ready[ch] = (hold == 0);
    issue(ch, a, b);
    s_load = cnt_load[ch]; s_add = cnt_add[ch]; s_shr = cnt_shr[ch];
    s_incr = cnt_incr[ch]; s_idle = cnt_idle[ch];
    wait_resp(ch, 1'b1, "resp_arrive");
    check($sformatf("ch%0d_load_cycles", ch), 64'(cnt_load[ch] - s_load), 64'd1);
    check($sformatf("ch%0d_add_cycles", ch),  64'(cnt_add[ch] - s_add), 64'($countones(b)));
    check($sformatf("ch%0d_shr_cycles", ch),  64'(cnt_shr[ch] - s_shr), 64'd32);
    check($sformatf("ch%0d_incr_cycles", ch), 64'(cnt_incr[ch] - s_incr), 64'd32);
    check($sformatf("ch%0d_busy_gap", ch),    64'(cnt_idle[ch] - s_idle), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("ch%0d_held_product", ch), resp_product[ch], prod);
      check($sformatf("ch%0d_ready_in_done", ch), 64'(req_ready[ch]), 64'd0);
    end
    if (hold > 0) begin
      step();
      resp_ready[ch] = 1'b1;
    end
    wait_resp(ch, 1'b0, "resp_release");
  endtask

  task automatic check_reset(input int ch);
    check($sformatf("ch%0d_rst_req_ready", ch),  64'(req_ready[ch]), 64'd1);
    check($sformatf("ch%0d_rst_busy", ch),       64'(busy[ch]), 64'd0);
    check($sformatf("ch%0d_rst_resp_valid", ch), 64'(resp_valid[ch]), 64'd0);
    check($sformatf("ch%0d_rst_product", ch),    resp_product[ch], 64'd0);
    check($sformatf("ch%0d_rst_dp_mcand", ch),   64'(dp_mcand[ch]), 64'd0);
    check($sformatf("ch%0d_rst_dp_mplier", ch),  64'(dp_mplier[ch]), 64'd0);
    check($sformatf("ch%0d_rst_dp_load", ch),    64'(dp_load[ch]), 64'd1);
    check($sformatf("ch%0d_rst_strobes", ch),    64'({dp_add[ch], dp_shr[ch], dp_incr[ch]}), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [63:0] first_prod;
    req_valid  = '0;
    resp_ready = '1;
    for (int g = 0; g < 2; g++) begin
      req_mcand[g]  = '0;
      req_mplier[g] = '0;
    end
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    check_reset(0);
    check_reset(1);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("ch1_load_until_edge", 64'(dp_load[1]), 64'd1);
    @(negedge clk);
    check("ch1_load_falls_idle", 64'(dp_load[1]), 64'd0);

    run_op(1, 32'd3, 32'd5, 0);
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(0, 32'd7, 32'h0000_000B, 0);
    run_op(0, 32'hDEAD_BEEF, 32'd0, 0);
    run_op(1, 32'hDEAD_BEEF, 32'd0, 0);
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);

    // Backpressure: a second request offered while DONE must wait for IDLE.
    a = $urandom;
    b = $urandom;
    first_prod = 64'(a) * 64'(b);
    step();
    resp_ready[1] = 1'b0;
    issue(1, a, b);
    wait_resp(1, 1'b1, "bp_resp_arrive");
    step();
    req_mcand[1]  = 32'd2;
    req_mplier[1] = 32'd9;
    req_valid[1]  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("ch1_bp_product_stable", resp_product[1], first_prod);
      check("ch1_bp_req_ready", 64'(req_ready[1]), 64'd0);
      check("ch1_bp_resp_valid", 64'(resp_valid[1]), 64'd1);
    end
    step();
    resp_ready[1] = 1'b1;
    issue(1, 32'd2, 32'd9);
    wait_resp(1, 1'b1, "bp2_resp_arrive");
    wait_resp(1, 1'b0, "bp2_resp_release");

    // Reset mid-operation discards the partial product.
    step();
    issue(1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (11) step();
    rst = 1'b1;
    sb_q[0].delete();
    sb_q[1].delete();
    @(negedge clk);
    check_reset(1);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("ch1_post_rst_load_high", 64'(dp_load[1]), 64'd1);
    run_op(1, 32'd6, 32'd7, 0);

    for (int k = 0; k < 10; k++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd1 << $urandom_range(0, 31);
        1:       b = ~(32'd1 << $urandom_range(0, 31));
        default: b = $urandom;
      endcase
      run_op(k % 2, a, b, int'($urandom_range(0, 3)));
    end

    repeat (4) step();
    check("ch0_sb_empty", 64'(sb_q[0].size()), 64'd0);
    check("ch1_sb_empty", 64'(sb_q[1].size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
